rv32m_div_unit: RTL

- Iterative RV32M divide/remainder unit: DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU in the execute stage.
- Control logic issues a start pulse with operands and op select. The unit answers with busy/done and a held Result plus Z/N flags, matching the flag convention of the execute stage.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/rv32m_div_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rv32m_div_unit.sv
// rv32m_div_unit: iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring,
// one quotient bit per RUN cycle.
// Optional feature macro: RV32M_DIV_EARLY_OUT_EN. When defined, the unit skips
// the iteration loop whenever |B| > |A|, which gives quo=0 and rem=|A|.
//
// state | meaning
// IDLE  | waiting for start; operands decoded and latched on accept
// RUN   | one restoring iteration per cycle, counter counts 32 down to 1
// FIN   | sign fix, Result/DivByZero registered, done pulse raised for next cycle
//
// Result, DivByZero and done are registered out of FIN, so they appear in the
// cycle after FIN. busy also covers that done cycle, and a start in the done
// cycle is ignored. That makes done land in cycle 34 on the normal path and in
// cycle 2 on the fast paths, counting the accept cycle as cycle 0.
module rv32m_div_unit #(
  parameter int XLEN       = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      DivOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output logic            ZFlag,
  output logic            NFlag,
  output logic            DivByZero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [ITER_CNT_W-1:0] ITERS    = ITER_CNT_W'(XLEN);
  localparam logic [ITER_CNT_W-1:0] ITER_ONE = ITER_CNT_W'(1);
  localparam logic [XLEN-1:0]       INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t                state_q, state_d;
  logic [ITER_CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]       quo_q, rem_q, div_q, result_q;
  logic                  qneg_q, rneg_q, is_rem_q, dbz_q, dbz_out_q, done_q;

  logic            is_signed, b_zero, ovf, early, fast, accept;
  logic [XLEN-1:0] a_mag, b_mag, fin_val;
  logic [XLEN:0]   rem_sh, trial;

  // Operand decode: magnitudes, special cases and fast-path selection
  always_comb begin
    is_signed = ~DivOp[0];
    a_mag     = (is_signed && A[XLEN-1]) ? ('0 - A) : A;
    b_mag     = (is_signed && B[XLEN-1]) ? ('0 - B) : B;
    b_zero    = (B == '0);
    ovf       = is_signed && (A == INT_MIN) && (B == '1);
`ifdef RV32M_DIV_EARLY_OUT_EN
    early     = !b_zero && (b_mag > a_mag);
`else
    early     = 1'b0;
`endif
    fast      = b_zero || ovf || early;
    accept    = (state_q == S_IDLE) && start && !done_q;
  end

  // One restoring step and the sign-fixed final value
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, div_q};
    fin_val = is_rem_q ? (rneg_q ? ('0 - rem_q) : rem_q)
                       : (qneg_q ? ('0 - quo_q) : quo_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = fast ? S_FIN : S_RUN;
      S_RUN:   if (cnt_q == ITER_ONE) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration, result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      dbz_q     <= 1'b0;
      dbz_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_rem_q <= DivOp[1];
            div_q    <= b_mag;
            cnt_q    <= ITERS;
            if (b_zero) begin
              quo_q  <= '1;
              rem_q  <= A;
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
              dbz_q  <= 1'b1;
            end else if (ovf) begin
              quo_q  <= INT_MIN;
              rem_q  <= '0;
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
              dbz_q  <= 1'b0;
            end else begin
              // early-out preloads the finished pair; otherwise the dividend
              // sits in quo and is shifted out as quotient bits shift in
              quo_q  <= early ? '0 : a_mag;
              rem_q  <= early ? a_mag : '0;
              qneg_q <= is_signed && (A[XLEN-1] ^ B[XLEN-1]);
              rneg_q <= is_signed && A[XLEN-1];
              dbz_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
          rem_q <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          cnt_q <= cnt_q - ITER_ONE;
        end
        S_FIN: begin
          result_q  <= fin_val;
          dbz_out_q <= dbz_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE) || done_q;
    done      = done_q;
    Result    = result_q;
    DivByZero = dbz_out_q;
    ZFlag     = (result_q == '0);
    NFlag     = result_q[XLEN-1];
  end

endmodule
